// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator: pixel type,
// pattern mode encodings, run-state encoding and the colour-bar palette.
package video_pkg;

    localparam int COORD_W = 12;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_RAMP    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Left-to-right colour bars (RGB888).
    localparam pixel_t BAR_COLOR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic pixel_t gray(input logic [7:0] level);
        return {level, level, level};
    endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster position counters (x, y and colour-bar index) for the currently
// presented pixel, plus the wrapped position of the following pixel.
module pixel_counter
    import video_pkg::*;
#(
    parameter int Width  = 1040,
    parameter int Height = 666
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [2:0]         bar,
    output logic [COORD_W-1:0] x_next,
    output logic [COORD_W-1:0] y_next,
    output logic [2:0]         bar_next,
    output logic               last_pixel
);

    localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(Width - 1);
    localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(Height - 1);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(Width / 8 - 1);

    logic [COORD_W-1:0] x_reg, y_reg, bar_px_reg, bar_px_next;
    logic [2:0]         bar_reg;

    // The bar index steps every Width/8 pixels using a pixel-within-bar count.
    always_comb begin
        x_next      = x_reg + COORD_W'(1);
        y_next      = y_reg;
        bar_next    = bar_reg;
        bar_px_next = bar_px_reg + COORD_W'(1);
        if (bar_px_reg == BAR_LAST) begin
            bar_px_next = '0;
            bar_next    = bar_reg + 3'd1;
        end
        if (x_reg == LAST_X) begin
            x_next      = '0;
            bar_px_next = '0;
            bar_next    = '0;
            y_next      = (y_reg == LAST_Y) ? '0 : y_reg + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg      <= '0;
            y_reg      <= '0;
            bar_reg    <= '0;
            bar_px_reg <= '0;
        end else if (advance) begin
            x_reg      <= x_next;
            y_reg      <= y_next;
            bar_reg    <= bar_next;
            bar_px_reg <= bar_px_next;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign bar        = bar_reg;
    assign last_pixel = (x_reg == LAST_X) && (y_reg == LAST_Y);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: solid, colour bars, checkerboard or scrolling
// ramp, streamed one pixel per transfer over a valid/ready handshake.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int Width    = 1040,
    parameter int Height   = 666,
    parameter int TileLog2 = 5
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Enable,
    input  logic [1:0]  Mode,
    input  logic [23:0] SolidColor,
    output logic [23:0] Video,
    output logic        VideoValid,
    input  logic        VideoReady,
    output logic        StartOfFrame,
    output logic        EndOfLine,
    output logic [15:0] FrameCount
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(Width - 1);

    state_e             state_reg, state_next;
    pixel_t             video_reg, video_next;
    logic               valid_reg, valid_next;
    logic               sof_reg, sof_next;
    logic               eol_reg, eol_next;
    logic [15:0]        fc_reg, fc_next;
    mode_e              mode_reg, mode_next;
    pixel_t             color_reg, color_next;

    logic               transfer, load;
    logic [COORD_W-1:0] cnt_x, cnt_y, cnt_x_next, cnt_y_next;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic [2:0]         cnt_bar, cnt_bar_next, pix_bar;
    logic               last_pixel;

    assign transfer = valid_reg & VideoReady;

    pixel_counter #(
        .Width  (Width),
        .Height (Height)
    ) u_pixel_counter (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .advance    (transfer),
        .x          (cnt_x),
        .y          (cnt_y),
        .bar        (cnt_bar),
        .x_next     (cnt_x_next),
        .y_next     (cnt_y_next),
        .bar_next   (cnt_bar_next),
        .last_pixel (last_pixel)
    );

    function automatic pixel_t make_pixel(
        input mode_e              m,
        input pixel_t             c,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [2:0]         b,
        input logic [7:0]         f
    );
        pixel_t p;
        case (m)
            MODE_SOLID:   p = c;
            MODE_BARS:    p = BAR_COLOR[b];
            MODE_CHECKER: p = (px[TileLog2] ^ py[TileLog2]) ? '0 : c;
            MODE_RAMP:    p = gray(px[7:0] + f);
            default:      p = '0;
        endcase
        return p;
    endfunction

    // Output registers are loaded with the pixel about to be presented, so the
    // pattern is computed from the counters' upcoming position.
    always_comb begin
        state_next = state_reg;
        video_next = video_reg;
        valid_next = valid_reg;
        sof_next   = sof_reg;
        eol_next   = eol_reg;
        fc_next    = fc_reg;
        mode_next  = mode_reg;
        color_next = color_reg;
        load       = 1'b0;
        pix_x      = cnt_x_next;
        pix_y      = cnt_y_next;
        pix_bar    = cnt_bar_next;

        case (state_reg)
            ST_IDLE: begin
                pix_x   = cnt_x;
                pix_y   = cnt_y;
                pix_bar = cnt_bar;
                if (Enable) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                    mode_next  = mode_e'(Mode);
                    color_next = SolidColor;
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    if (last_pixel) begin
                        fc_next = fc_reg + 16'd1;
                        if (Enable) begin
                            load       = 1'b1;
                            mode_next  = mode_e'(Mode);
                            color_next = SolidColor;
                        end else begin
                            state_next = ST_IDLE;
                            valid_next = 1'b0;
                            sof_next   = 1'b0;
                            eol_next   = 1'b0;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            valid_next = 1'b1;
            video_next = make_pixel(mode_next, color_next, pix_x, pix_y, pix_bar, fc_next[7:0]);
            sof_next   = (pix_x == '0) && (pix_y == '0);
            eol_next   = (pix_x == LAST_X);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            video_reg <= '0;
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            fc_reg    <= '0;
            mode_reg  <= MODE_SOLID;
            color_reg <= '0;
        end else begin
            state_reg <= state_next;
            video_reg <= video_next;
            valid_reg <= valid_next;
            sof_reg   <= sof_next;
            eol_reg   <= eol_next;
            fc_reg    <= fc_next;
            mode_reg  <= mode_next;
            color_reg <= color_next;
        end
    end

    assign Video        = video_reg;
    assign VideoValid   = valid_reg;
    assign StartOfFrame = sof_reg;
    assign EndOfLine    = eol_reg;
    assign FrameCount   = fc_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 16x4 raster with 2-pixel tiles.
module tb_video_pattern_gen;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Enable = 1'b0;
    logic [1:0]  Mode = 2'd0;
    logic [23:0] SolidColor = 24'h0;
    logic [23:0] Video;
    logic        VideoValid;
    logic        VideoReady = 1'b0;
    logic        StartOfFrame;
    logic        EndOfLine;
    logic [15:0] FrameCount;

    int tests = 0;
    int fails = 0;

    video_pattern_gen #(
        .Width    (16),
        .Height   (4),
        .TileLog2 (1)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Enable       (Enable),
        .Mode         (Mode),
        .SolidColor   (SolidColor),
        .Video        (Video),
        .VideoValid   (VideoValid),
        .VideoReady   (VideoReady),
        .StartOfFrame (StartOfFrame),
        .EndOfLine    (EndOfLine),
        .FrameCount   (FrameCount)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] bar_exp(input int x);
        case (x / 2)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Enable = 1'b0;
        VideoReady = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Enable = 1'b1;
        step();
        step();
        tests++;
        if (VideoValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", VideoValid); end
        tests++;
        if (Video !== 24'h0) begin fails++; $display("FAIL reset_video got %h exp 000000", Video); end
        tests++;
        if (FrameCount !== 16'd0) begin fails++; $display("FAIL reset_fc got %0d exp 0", FrameCount); end
        tests++;
        if (StartOfFrame !== 1'b0 || EndOfLine !== 1'b0) begin
            fails++; $display("FAIL reset_flags got sof=%b eol=%b exp 0 0", StartOfFrame, EndOfLine);
        end
        Enable = 1'b0;
        Reset_n = 1'b1;
        step();
        tests++;
        if (VideoValid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b exp 0", VideoValid); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_bars();
        Mode = 2'd1;
        VideoReady = 1'b1;
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tests++;
            if (VideoValid !== 1'b1 || Video !== bar_exp(i % 16)) begin
                fails++; $display("FAIL bars_pixel i=%0d got v=%b %h exp v=1 %h", i, VideoValid, Video, bar_exp(i % 16));
            end
            tests++;
            if (EndOfLine !== ((i % 16) == 15) || StartOfFrame !== (i == 0)) begin
                fails++; $display("FAIL bars_flags i=%0d got sof=%b eol=%b exp sof=%b eol=%b",
                                  i, StartOfFrame, EndOfLine, i == 0, (i % 16) == 15);
            end
            step();
        end
        tests++;
        if (VideoValid !== 1'b0 || FrameCount !== 16'd1) begin
            fails++; $display("FAIL bars_end got v=%b fc=%0d exp v=0 fc=1", VideoValid, FrameCount);
        end
        $display("[TB] test_bars done fc=%0d", FrameCount);
    endtask

    task automatic test_solid_stall();
        int          transfers = 0;
        int          eols = 0;
        logic [15:0] fc0;
        logic [23:0] pv;
        logic        psof, peol, r;
        fc0 = FrameCount;
        Mode = 2'd0;
        SolidColor = 24'hFF00FF;
        VideoReady = 1'b0;
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        for (int c = 0; c < 300 && VideoValid === 1'b1; c++) begin
            r = (c % 2) == 1;
            VideoReady = r;
            tests++;
            if (Video !== 24'hFF00FF) begin fails++; $display("FAIL solid_pixel c=%0d got %h exp ff00ff", c, Video); end
            pv = Video;
            psof = StartOfFrame;
            peol = EndOfLine;
            if (r) begin
                transfers++;
                if (peol) eols++;
            end
            step();
            if (!r) begin
                tests++;
                if (VideoValid !== 1'b1 || Video !== pv || StartOfFrame !== psof || EndOfLine !== peol) begin
                    fails++; $display("FAIL solid_stall c=%0d got v=%b %h sof=%b eol=%b exp v=1 %h sof=%b eol=%b",
                                      c, VideoValid, Video, StartOfFrame, EndOfLine, pv, psof, peol);
                end
            end
        end
        tests++;
        if (transfers != 64 || eols != 4) begin
            fails++; $display("FAIL solid_count got transfers=%0d eols=%0d exp 64 4", transfers, eols);
        end
        tests++;
        if (VideoValid !== 1'b0 || FrameCount !== fc0 + 16'd1) begin
            fails++; $display("FAIL solid_end got v=%b fc=%0d exp v=0 fc=%0d", VideoValid, FrameCount, fc0 + 16'd1);
        end
        $display("[TB] test_solid_stall done transfers=%0d", transfers);
    endtask

    task automatic test_checker();
        logic [23:0] exp;
        Mode = 2'd2;
        SolidColor = 24'h00FF00;
        VideoReady = 1'b1;
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        SolidColor = 24'h123456;
        for (int i = 0; i < 64; i++) begin
            exp = ((((i % 16) / 2) ^ ((i / 16) / 2)) % 2 == 1) ? 24'h000000 : 24'h00FF00;
            tests++;
            if (Video !== exp) begin fails++; $display("FAIL checker_pixel x=%0d y=%0d got %h exp %h", i % 16, i / 16, Video, exp); end
            step();
        end
        tests++;
        if (VideoValid !== 1'b0) begin fails++; $display("FAIL checker_end got v=%b exp 0", VideoValid); end
        $display("[TB] test_checker done");
    endtask

    task automatic test_ramp();
        logic [7:0] lv;
        do_reset();
        Mode = 2'd3;
        VideoReady = 1'b1;
        Enable = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                if (f == 1 && i == 10) Enable = 1'b0;
                lv = 8'((i % 16) + f);
                tests++;
                if (VideoValid !== 1'b1 || Video !== {lv, lv, lv} || StartOfFrame !== (i == 0)) begin
                    fails++; $display("FAIL ramp_pixel f=%0d i=%0d got v=%b %h sof=%b exp v=1 %h sof=%b",
                                      f, i, VideoValid, Video, StartOfFrame, {lv, lv, lv}, i == 0);
                end
                if (i == 63) begin
                    tests++;
                    if (FrameCount !== 16'(f)) begin fails++; $display("FAIL ramp_fc_before f=%0d got %0d exp %0d", f, FrameCount, f); end
                end
                step();
            end
            tests++;
            if (FrameCount !== 16'(f + 1)) begin fails++; $display("FAIL ramp_fc_after f=%0d got %0d exp %0d", f, FrameCount, f + 1); end
        end
        tests++;
        if (VideoValid !== 1'b0) begin fails++; $display("FAIL ramp_end got v=%b exp 0", VideoValid); end
        $display("[TB] test_ramp done fc=%0d", FrameCount);
    endtask

    task automatic test_enable_drop();
        do_reset();
        Mode = 2'd1;
        VideoReady = 1'b1;
        Enable = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            if (i == 19) begin
                Enable = 1'b0;
                Mode = 2'd0;
                SolidColor = 24'hABCDEF;
            end
            tests++;
            if (VideoValid !== 1'b1 || Video !== bar_exp(i % 16)) begin
                fails++; $display("FAIL drop_pixel i=%0d got v=%b %h exp v=1 %h", i, VideoValid, Video, bar_exp(i % 16));
            end
            step();
        end
        tests++;
        if (VideoValid !== 1'b0 || FrameCount !== 16'd1) begin
            fails++; $display("FAIL drop_end got v=%b fc=%0d exp v=0 fc=1", VideoValid, FrameCount);
        end
        step();
        tests++;
        if (VideoValid !== 1'b0) begin fails++; $display("FAIL drop_idle got v=%b exp 0", VideoValid); end
        $display("[TB] test_enable_drop done");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        Mode = 2'd0;
        SolidColor = 24'h123456;
        VideoReady = 1'b1;
        Enable = 1'b1;
        step();
        for (int i = 0; i < 39; i++) step();
        tests++;
        if (VideoValid !== 1'b1 || EndOfLine !== 1'b0 || StartOfFrame !== 1'b0) begin
            fails++; $display("FAIL mid_pre got v=%b sof=%b eol=%b exp 1 0 0", VideoValid, StartOfFrame, EndOfLine);
        end
        Reset_n = 1'b0;
        #1;
        tests++;
        if (VideoValid !== 1'b0 || FrameCount !== 16'd0 || Video !== 24'h0) begin
            fails++; $display("FAIL mid_reset got v=%b fc=%0d %h exp 0 0 000000", VideoValid, FrameCount, Video);
        end
        step();
        Reset_n = 1'b1;
        step();
        Enable = 1'b0;
        tests++;
        if (VideoValid !== 1'b1 || StartOfFrame !== 1'b1 || Video !== 24'h123456) begin
            fails++; $display("FAIL mid_restart got v=%b sof=%b %h exp 1 1 123456", VideoValid, StartOfFrame, Video);
        end
        for (int c = 0; c < 200 && VideoValid === 1'b1; c++) begin
            n++;
            step();
        end
        tests++;
        if (n != 64 || FrameCount !== 16'd1) begin
            fails++; $display("FAIL mid_frame got transfers=%0d fc=%0d exp 64 1", n, FrameCount);
        end
        $display("[TB] test_reset_mid done transfers=%0d", n);
    endtask

    initial begin
        test_reset();
        test_bars();
        test_solid_stall();
        test_checker();
        test_ramp();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
